// File: rtl/bn_rr_stream_mux_n_1.sv
// rtl/bn_rr_stream_mux_n_1.sv - registered N-to-1 stream mux with round-robin or fixed-priority arbitration
module bn_rr_stream_mux_n_1 #(
    parameter int DATA_WIDTH     = 8,
    parameter int INPUT_CHANNELS = 4,
    parameter int MODE           = 0,
    localparam int SEL_WIDTH     = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [INPUT_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [INPUT_CHANNELS-1:0]            in_valid,
    output logic [INPUT_CHANNELS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [SEL_WIDTH-1:0]                 out_chan,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_chan_q, out_chan_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;

    logic                      load_en;
    logic                      transfer;
    logic                      grant_found;
    logic [SEL_WIDTH-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0]     grant_data;
    logic [INPUT_CHANNELS-1:0] hi_req;
    int                        scan_start;

    assign load_en = !out_valid_q || out_ready;

    // Requests at or above the pointer win first; otherwise wrap to the lowest requester.
    always_comb begin
        scan_start  = (MODE == 0) ? int'(ptr_q) : 0;
        hi_req      = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < INPUT_CHANNELS; k++) begin
            hi_req[k] = in_valid[k] && (k >= scan_start);
        end
        if (|hi_req) begin
            grant_found = 1'b1;
            for (int k = INPUT_CHANNELS - 1; k >= 0; k--) begin
                if (hi_req[k]) begin
                    grant_idx = SEL_WIDTH'(k);
                end
            end
        end else if (|in_valid) begin
            grant_found = 1'b1;
            for (int k = INPUT_CHANNELS - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    grant_idx = SEL_WIDTH'(k);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < INPUT_CHANNELS; k++) begin
            if (grant_idx == SEL_WIDTH'(k)) begin
                grant_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready is masked during reset so no source sees a handshake that would be discarded.
    assign transfer = rst_n && load_en && grant_found;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < INPUT_CHANNELS; k++) begin
            in_ready[k] = transfer && (grant_idx == SEL_WIDTH'(k));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            if (MODE == 0) begin
                ptr_d = (int'(grant_idx) == INPUT_CHANNELS - 1) ? '0 : grant_idx + 1'b1;
            end else begin
                ptr_d = '0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_bn_rr_stream_mux_n_1.sv
// tb/tb_bn_rr_stream_mux_n_1.sv - directed bench for round-robin, fixed-priority and 3-channel muxes
module tb_bn_rr_stream_mux_n_1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] rr_in_data, fp_in_data;
    logic [3:0]  rr_in_valid, rr_in_ready, fp_in_valid, fp_in_ready;
    logic [7:0]  rr_out_data, fp_out_data;
    logic [1:0]  rr_out_chan, fp_out_chan;
    logic        rr_out_valid, rr_out_ready, fp_out_valid, fp_out_ready;

    logic [23:0] n3_in_data;
    logic [2:0]  n3_in_valid, n3_in_ready;
    logic [7:0]  n3_out_data;
    logic [1:0]  n3_out_chan;
    logic        n3_out_valid, n3_out_ready;

    bn_rr_stream_mux_n_1 #(.DATA_WIDTH(8), .INPUT_CHANNELS(4), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(rr_in_data), .in_valid(rr_in_valid),
        .in_ready(rr_in_ready), .out_data(rr_out_data), .out_chan(rr_out_chan),
        .out_valid(rr_out_valid), .out_ready(rr_out_ready));

    bn_rr_stream_mux_n_1 #(.DATA_WIDTH(8), .INPUT_CHANNELS(4), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(fp_in_data), .in_valid(fp_in_valid),
        .in_ready(fp_in_ready), .out_data(fp_out_data), .out_chan(fp_out_chan),
        .out_valid(fp_out_valid), .out_ready(fp_out_ready));

    bn_rr_stream_mux_n_1 #(.DATA_WIDTH(8), .INPUT_CHANNELS(3), .MODE(0)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .in_data(n3_in_data), .in_valid(n3_in_valid),
        .in_ready(n3_in_ready), .out_data(n3_out_data), .out_chan(n3_out_chan),
        .out_valid(n3_out_valid), .out_ready(n3_out_ready));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rr_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; rr_in_valid = 4'hF; rr_out_ready = 1'b1;
        fp_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; fp_in_valid = 4'h0; fp_out_ready = 1'b1;
        n3_in_data = {8'hA2, 8'hA1, 8'hA0};        n3_in_valid = 3'h0; n3_out_ready = 1'b1;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (rr_in_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_in_ready cycle %0d: got %b want 0000", c, rr_in_ready);
            end
            checks++;
            if ({rr_out_valid, rr_out_chan, rr_out_data} !== 11'h0) begin
                errors++; $display("FAIL reset_outputs cycle %0d: got valid=%b chan=%0d data=%h want 0/0/00",
                                   c, rr_out_valid, rr_out_chan, rr_out_data);
            end
        end
        rr_in_valid = 4'h0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        rr_in_valid = 4'hF; rr_out_ready = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            errors++; $display("FAIL rr_first_grant: got %b want 0001", rr_in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] exp_data;
            logic [1:0] exp_chan;
            exp_chan = 2'(i % 4);
            exp_data = 8'hA0 + 8'(i % 4);
            tick();
            checks++;
            if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, exp_chan, exp_data}) begin
                errors++; $display("FAIL rr_stream beat %0d: got valid=%b chan=%0d data=%h want 1/%0d/%h",
                                   i, rr_out_valid, rr_out_chan, rr_out_data, exp_chan, exp_data);
            end
        end
    endtask

    task automatic test_hold();
        rr_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rr_in_ready !== 4'b0000) begin
                errors++; $display("FAIL hold_in_ready cycle %0d: got %b want 0000", c, rr_in_ready);
            end
            tick();
            checks++;
            if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd1, 8'hA1}) begin
                errors++; $display("FAIL hold_output cycle %0d: got valid=%b chan=%0d data=%h want 1/1/a1",
                                   c, rr_out_valid, rr_out_chan, rr_out_data);
            end
        end
        rr_out_ready = 1'b1;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0100) begin
            errors++; $display("FAIL release_grant: got %b want 0100", rr_in_ready);
        end
        tick();
        checks++;
        if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd2, 8'hA2}) begin
            errors++; $display("FAIL release_no_bubble: got valid=%b chan=%0d data=%h want 1/2/a2",
                               rr_out_valid, rr_out_chan, rr_out_data);
        end
        rr_in_valid = 4'h0;
        tick();
        checks++;
        if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b0, 2'd2, 8'hA2}) begin
            errors++; $display("FAIL drain_keeps_word: got valid=%b chan=%0d data=%h want 0/2/a2",
                               rr_out_valid, rr_out_chan, rr_out_data);
        end
    endtask

    task automatic test_rr_skip();
        // ptr is 3 here; a lone ch0 request wraps and leaves ptr at 1
        rr_in_valid = 4'b0001;
        tick();
        checks++;
        if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            errors++; $display("FAIL skip_setup: got valid=%b chan=%0d data=%h want 1/0/a0",
                               rr_out_valid, rr_out_chan, rr_out_data);
        end
        rr_in_valid = 4'b0101;
        #1;
        checks++;
        if (rr_in_ready !== 4'b0100) begin
            errors++; $display("FAIL skip_grant_ch2: got %b want 0100", rr_in_ready);
        end
        tick();
        checks++;
        if ({rr_out_chan, rr_out_data} !== {2'd2, 8'hA2}) begin
            errors++; $display("FAIL skip_take_ch2: got chan=%0d data=%h want 2/a2", rr_out_chan, rr_out_data);
        end
        checks++;
        if (rr_in_ready !== 4'b0001) begin
            errors++; $display("FAIL skip_grant_ch0: got %b want 0001", rr_in_ready);
        end
        tick();
        checks++;
        if ({rr_out_chan, rr_out_data} !== {2'd0, 8'hA0}) begin
            errors++; $display("FAIL skip_take_ch0: got chan=%0d data=%h want 0/a0", rr_out_chan, rr_out_data);
        end
        rr_in_valid = 4'b1000;
        #1;
        checks++;
        if (rr_in_ready !== 4'b1000) begin
            errors++; $display("FAIL lone_ch3_grant: got %b want 1000", rr_in_ready);
        end
        tick();
        checks++;
        if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd3, 8'hA3}) begin
            errors++; $display("FAIL lone_ch3_take: got valid=%b chan=%0d data=%h want 1/3/a3",
                               rr_out_valid, rr_out_chan, rr_out_data);
        end
        rr_in_valid = 4'h0;
        tick();
    endtask

    task automatic test_fixed_priority();
        fp_in_valid = 4'b1001; fp_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (fp_in_ready !== 4'b0001) begin
                errors++; $display("FAIL fp_grant cycle %0d: got %b want 0001", i, fp_in_ready);
            end
            tick();
            checks++;
            if ({fp_out_valid, fp_out_chan, fp_out_data} !== {1'b1, 2'd0, 8'hA0}) begin
                errors++; $display("FAIL fp_take_ch0 cycle %0d: got valid=%b chan=%0d data=%h want 1/0/a0",
                                   i, fp_out_valid, fp_out_chan, fp_out_data);
            end
        end
        fp_in_valid = 4'b1000;
        tick();
        checks++;
        if ({fp_out_valid, fp_out_chan, fp_out_data} !== {1'b1, 2'd3, 8'hA3}) begin
            errors++; $display("FAIL fp_take_ch3: got valid=%b chan=%0d data=%h want 1/3/a3",
                               fp_out_valid, fp_out_chan, fp_out_data);
        end
        fp_in_valid = 4'h0;
        tick();
    endtask

    task automatic test_three_channel();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};
        n3_in_valid = 3'b111; n3_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({n3_out_valid, n3_out_data} !== {1'b1, exp_seq[i]}) begin
                errors++; $display("FAIL n3_wrap beat %0d: got valid=%b data=%h want 1/%h",
                                   i, n3_out_valid, n3_out_data, exp_seq[i]);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (n3_in_ready !== 3'b000) begin
            errors++; $display("FAIL n3_reset_ready: got %b want 000", n3_in_ready);
        end
        tick();
        checks++;
        if ({n3_out_valid, n3_out_chan, n3_out_data} !== 11'h0) begin
            errors++; $display("FAIL n3_midstream_reset: got valid=%b chan=%0d data=%h want 0/0/00",
                               n3_out_valid, n3_out_chan, n3_out_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (n3_in_ready !== 3'b001) begin
            errors++; $display("FAIL n3_ptr_after_reset: got %b want 001", n3_in_ready);
        end
        tick();
        checks++;
        if ({n3_out_valid, n3_out_chan, n3_out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            errors++; $display("FAIL n3_restart: got valid=%b chan=%0d data=%h want 1/0/a0",
                               n3_out_valid, n3_out_chan, n3_out_data);
        end
        n3_in_valid = 3'b000;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_rr_skip();
        test_fixed_priority();
        test_three_channel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
